nibble_serial_addsub: RTL

//   Multi-cycle WIDTH-bit adder/subtractor that processes one 4-bit nibble per clock, LSB first.

---
 rtl/nibble_serial_addsub.sv | 135 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial WIDTH-bit adder/subtractor: one 4-bit propagate/generate slice per clock, LSB first.
// Produces result plus carry/zero/overflow and unsigned/signed less-than flags for subtraction.
module nibble_serial_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow,
    output logic             lt_unsigned,
    output logic             lt_signed
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int MSB     = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_eff;
    logic             sub_op;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       sum_nib;
    logic             nib_cout;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;
    logic             accept;

    function automatic logic [4:0] nibble_add(input logic [3:0] x, input logic [3:0] y,
                                              input logic cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = cin;
        for (int k = 0; k < 4; k++) begin
            c[k+1] = g[k] | (p[k] & c[k]);
        end
        return {c[4], p ^ c[3:0]};
    endfunction

    assign accept = (state == IDLE) && start;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    // Current nibble slice and the result as it will look once this nibble is written
    always_comb begin
        a_nib               = a_op[{idx, 2'b00} +: 4];
        b_nib               = b_eff[{idx, 2'b00} +: 4];
        {nib_cout, sum_nib} = nibble_add(a_nib, b_nib, carry);
        res_next            = result;
        res_next[{idx, 2'b00} +: 4] = sum_nib;
        ovf_next            = (a_op[MSB] == b_eff[MSB]) && (res_next[MSB] != a_op[MSB]);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (idx == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latches only change on an accepted start, so they need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            a_op   <= a;
            b_eff  <= sub ? ~b : b;
            sub_op <= sub;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            carry       <= 1'b0;
            idx         <= '0;
            result      <= '0;
            carry_out   <= 1'b0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            lt_unsigned <= 1'b0;
            lt_signed   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                carry       <= sub;
                idx         <= '0;
                result      <= '0;
                carry_out   <= 1'b0;
                zero        <= 1'b0;
                overflow    <= 1'b0;
                lt_unsigned <= 1'b0;
                lt_signed   <= 1'b0;
            end else if (state == RUN) begin
                result <= res_next;
                carry  <= nib_cout;
                idx    <= idx + 1'b1;
                // Flags land together with the final nibble so they are valid during done
                if (idx == LAST) begin
                    carry_out   <= nib_cout;
                    zero        <= (res_next == '0);
                    overflow    <= ovf_next;
                    lt_unsigned <= sub_op & ~nib_cout;
                    lt_signed   <= sub_op & (res_next[MSB] ^ ovf_next);
                end
            end
        end
    end

endmodule
